// File: rtl/unary_root_two_scheduler_pkg.sv
// unary_sched_pkg: shared state encoding, stream encodings and round-robin pick for the unary root scheduler
package unary_sched_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESPOND} state_t;
  localparam int ENC_THERM = 0;
  localparam int ENC_SPREAD = 1;
  localparam int MAX_REQ = 64;
  // Scans from the far end so the requester nearest the pointer wins.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    rr_pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--)
      if (k < n && req[(ptr + k) % n]) rr_pick = (ptr + k) % n;
  endfunction
endpackage

// File: rtl/unary_root_two_scheduler_if.sv
// unary_root_two_scheduler_if: request, response and unary-unit signals of the scheduler
interface unary_root_two_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int COUNT_WIDTH = 6,
  parameter int ID_WIDTH = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*COUNT_WIDTH-1:0] req_value;
  logic [NUM_REQ-1:0] req_ready;
  logic resp_valid;
  logic resp_ready;
  logic [ID_WIDTH-1:0] resp_id;
  logic [COUNT_WIDTH-1:0] resp_value;
  logic resp_err;
  logic unit_reset_n;
  logic unit_a;
  logic unit_ready;
  logic unit_valid;
  logic unit_y;
  logic busy;
  modport master (
    output req_valid, req_value, resp_ready, unit_valid, unit_y,
    input req_ready, resp_valid, resp_id, resp_value, resp_err, unit_reset_n, unit_a, unit_ready, busy
  );
  modport slave (
    input req_valid, req_value, resp_ready, unit_valid, unit_y,
    output req_ready, resp_valid, resp_id, resp_value, resp_err, unit_reset_n, unit_a, unit_ready, busy
  );
endinterface

// File: rtl/unary_root_two_scheduler_enc.sv
// unary_stream_encoder: turns a captured binary value into a registered unary bit stream
module unary_stream_encoder
  import unary_sched_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
  parameter int ENCODING = ENC_SPREAD
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  input  logic [COUNT_WIDTH-1:0] value,
  output logic a
);
  localparam logic [COUNT_WIDTH:0] AW = (COUNT_WIDTH + 1)'(INPUT_WIDTH);
  logic [COUNT_WIDTH-1:0] val, idx, cur_val, cur_idx;
  logic [COUNT_WIDTH:0] acc, cur_acc, sum;
  logic hit, bit_n;
  // On load the first bit is computed from the incoming value so it appears in the first stream cycle.
  always_comb begin
    cur_val = load ? value : val;
    cur_idx = load ? '0 : idx;
    cur_acc = load ? '0 : acc;
    sum = cur_acc + {1'b0, cur_val};
    hit = sum >= AW;
    bit_n = (ENCODING == ENC_SPREAD) ? hit : (cur_idx < cur_val);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      val <= '0;
      idx <= '0;
      acc <= '0;
      a <= 1'b0;
    end else begin
      if (load) val <= value;
      a <= (load || en) && bit_n;
      if (load || en) begin
        idx <= cur_idx + 1'b1;
        acc <= hit ? sum - AW : sum;
      end
    end
endmodule

// File: rtl/unary_root_two_scheduler.sv
// unary_root_two_scheduler: round-robin sharing of one unary square-root unit among binary requesters
module unary_root_two_scheduler
  import unary_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
  parameter int ID_WIDTH = $clog2(NUM_REQ),
  parameter int ENCODING = ENC_SPREAD,
  parameter int TIMEOUT = 4 * INPUT_WIDTH
) (
  input logic clk,
  input logic reset,
  unary_root_two_scheduler_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [COUNT_WIDTH-1:0] W = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] W_LAST = COUNT_WIDTH'(INPUT_WIDTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  state_t state, nxt;
  logic [MAX_REQ-1:0] rq;
  logic [ID_WIDTH-1:0] ptr, id, g;
  logic [COUNT_WIDTH-1:0] req_v, cap, y_cnt, y_ones, cnt_n, ones_n, s_cnt;
  logic [TW-1:0] d_cnt;
  logic grant, collect, last, tmo, done, step, err;
  always_comb begin
    rq = '0;
    rq[NUM_REQ-1:0] = bus.req_valid;
    g = ID_WIDTH'(rr_pick(rq, int'(ptr), NUM_REQ));
    req_v = bus.req_value[g*COUNT_WIDTH +: COUNT_WIDTH];
    cap = (req_v > W) ? W : req_v;
    grant = (state == IDLE) && |bus.req_valid;
    collect = (state == STREAM || state == DRAIN) && bus.unit_valid && (y_cnt < W);
    cnt_n = y_cnt + COUNT_WIDTH'(collect);
    ones_n = y_ones + COUNT_WIDTH'(collect && bus.unit_y);
    last = (state == STREAM) && (s_cnt == W_LAST);
    tmo = (state == DRAIN) && (d_cnt == T_LAST);
    done = cnt_n == W;
    nxt = grant ? STREAM :
          last ? (done ? RESPOND : DRAIN) :
          (state == DRAIN && (done || tmo)) ? RESPOND :
          (state == RESPOND && bus.resp_ready) ? IDLE : state;
    step = (state == STREAM) && (nxt == STREAM);
  end
  // Outputs are registered from next-state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      y_cnt <= '0;
      y_ones <= '0;
      s_cnt <= '0;
      d_cnt <= '0;
      err <= 1'b0;
      bus.req_ready <= '0;
      bus.resp_valid <= 1'b0;
      bus.unit_reset_n <= 1'b0;
      bus.unit_ready <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      state <= nxt;
      bus.req_ready <= grant ? NUM_REQ'(1) << g : '0;
      bus.resp_valid <= nxt == RESPOND;
      bus.unit_reset_n <= nxt == STREAM || nxt == DRAIN;
      bus.unit_ready <= nxt == STREAM;
      bus.busy <= nxt != IDLE;
      s_cnt <= (state == STREAM) ? s_cnt + 1'b1 : '0;
      d_cnt <= (state == DRAIN) ? d_cnt + 1'b1 : '0;
      if (grant) begin
        id <= g;
        ptr <= (g == ID_WIDTH'(NUM_REQ - 1)) ? '0 : g + 1'b1;
        y_cnt <= '0;
        y_ones <= '0;
        err <= 1'b0;
      end else begin
        y_cnt <= cnt_n;
        y_ones <= ones_n;
        if (tmo && !done) err <= 1'b1;
      end
    end
  assign bus.resp_id = id;
  assign bus.resp_value = y_ones;
  assign bus.resp_err = err;
  unary_stream_encoder #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH),
    .ENCODING(ENCODING)
  ) u_enc (
    .clk(clk),
    .reset(reset),
    .load(grant),
    .en(step),
    .value(cap),
    .a(bus.unit_a)
  );
endmodule

// File: tb/tb_unary_root_two_scheduler.sv
// tb_unary_root_two_scheduler: scoreboard bench with a batch square-root unit model
module tb_unary_root_two_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  unary_root_two_scheduler_if #(.NUM_REQ(4), .COUNT_WIDTH(6), .ID_WIDTH(2)) bus ();
  unary_root_two_scheduler_if #(.NUM_REQ(4), .COUNT_WIDTH(6), .ID_WIDTH(2)) th ();

  unary_root_two_scheduler #(.NUM_REQ(4), .INPUT_WIDTH(32), .ENCODING(1), .TIMEOUT(128)) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );
  unary_root_two_scheduler #(.NUM_REQ(4), .INPUT_WIDTH(32), .ENCODING(0), .TIMEOUT(128)) u_th (
    .clk(clk), .reset(rst_n), .bus(th)
  );

  typedef struct {int id; int value; bit err; int drain;} exp_t;
  typedef struct {int na; logic [31:0] pat; bit pchk;} uexp_t;
  exp_t exp_q[$];
  int gnt_q[$];
  uexp_t u_q[$];
  int total = 0, bad = 0;
  bit stall20 = 1'b0;
  bit re_on[4];
  int re_val[4];
  int th_nin = 0;
  logic [31:0] th_pat = '0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int rsqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    if (x - r * r > r) r++;
    return (r > 32) ? 32 : r;
  endfunction

  task automatic set_req(input int i, input int v);
    bus.req_valid[i] = 1'b1;
    bus.req_value[i*6 +: 6] = 6'(v);
  endtask

  task automatic expect_job(input int i, input int na, input int val, input bit err, input int drain,
                            input logic [31:0] pat, input bit pchk);
    exp_t e;
    uexp_t u;
    e.id = i; e.value = val; e.err = err; e.drain = drain;
    u.na = na; u.pat = pat; u.pchk = pchk;
    exp_q.push_back(e);
    gnt_q.push_back(i);
    u_q.push_back(u);
  endtask

  task automatic job(input int i, input int v, input int val, input bit err, input int drain,
                     input logic [31:0] pat, input bit pchk);
    expect_job(i, (v > 32) ? 32 : v, val, err, drain, pat, pchk);
    set_req(i, v);
  endtask

  // Requesters drop (or swap to a queued re-request) on their accept pulse.
  task automatic tick;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (bus.req_ready[i]) begin
        if (re_on[i]) begin
          bus.req_value[i*6 +: 6] = 6'(re_val[i]);
          re_on[i] = 1'b0;
        end else bus.req_valid[i] = 1'b0;
      end
  endtask

  task automatic wait_done(input int max);
    for (int c = 0; c < max; c++) begin
      tick();
      if (exp_q.size() == 0 && gnt_q.size() == 0 && !bus.busy) return;
    end
    total++;
    bad++;
    $display("FAIL wait_done: timed out with %0d responses pending", exp_q.size());
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_resp_id"}, bus.resp_id, 0);
    chk({tag, "_resp_value"}, bus.resp_value, 0);
    chk({tag, "_resp_err"}, bus.resp_err, 0);
    chk({tag, "_unit_reset_n"}, bus.unit_reset_n, 0);
    chk({tag, "_unit_a"}, bus.unit_a, 0);
    chk({tag, "_unit_ready"}, bus.unit_ready, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  // Unit model: collects the input stream, then emits round(sqrt(ones*W)) ones as a thermometer, with gaps.
  always @(negedge clk) begin : unit
    static int nin = 0, na = 0, nout = 0, ph = 0, k = 0;
    static logic [31:0] pat = '0;
    uexp_t u;
    if (!bus.unit_reset_n) begin
      nin = 0; na = 0; nout = 0; ph = 0; pat = '0;
      bus.unit_valid = 1'b0;
      bus.unit_y = 1'b0;
    end else begin
      if (nin == 32 && nout < 32 && !(stall20 && nout >= 20) && ph % 5 != 4) begin
        bus.unit_valid = 1'b1;
        bus.unit_y = nout < k;
        nout++;
      end else begin
        bus.unit_valid = 1'b0;
        bus.unit_y = 1'b0;
      end
      if (nin == 32) ph++;
      if (bus.unit_ready && nin < 32) begin
        pat[nin] = bus.unit_a;
        na += int'(bus.unit_a);
        nin++;
        if (nin == 32) begin
          k = rsqrt(na * 32);
          chk("unit_pending", int'(u_q.size() > 0), 1);
          if (u_q.size() > 0) begin
            u = u_q.pop_front();
            chk("ones_in", na, u.na);
            if (u.pchk) chk("pattern", pat, u.pat);
          end
        end
      end
    end
  end

  always @(negedge clk) begin : mon
    static logic [3:0] prev_rr = '0;
    static int low_run = 0, drain_run = 0;
    static bit stalled = 1'b0;
    static int s_id = 0, s_val = 0, s_err = 0;
    int g;
    exp_t e;
    if (bus.req_ready != 0) begin
      drain_run = 0;
      chk("grant_pending", int'(gnt_q.size() > 0), 1);
      if (gnt_q.size() > 0) begin
        g = gnt_q.pop_front();
        chk("grant", bus.req_ready, 1 << g);
        chk("grant_pulse_prev", prev_rr, 0);
      end
    end
    prev_rr = bus.req_ready;
    if (bus.unit_reset_n) begin
      if (low_run > 0) chk("unit_reset_gap", int'(low_run >= 2), 1);
      low_run = 0;
    end else low_run++;
    if (bus.busy && bus.unit_reset_n && !bus.unit_ready) drain_run++;
    if (bus.resp_valid) begin
      if (stalled) begin
        chk("stall_id", bus.resp_id, s_id);
        chk("stall_value", bus.resp_value, s_val);
        chk("stall_err", bus.resp_err, s_err);
        chk("stall_no_grant", bus.req_ready, 0);
      end
      if (!bus.resp_ready) begin
        stalled = 1'b1;
        s_id = bus.resp_id; s_val = bus.resp_value; s_err = bus.resp_err;
      end else begin
        stalled = 1'b0;
        chk("resp_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("resp_id", bus.resp_id, e.id);
          chk("resp_value", bus.resp_value, e.value);
          chk("resp_err", bus.resp_err, int'(e.err));
          if (e.drain >= 0) chk("drain_cycles", drain_run, e.drain);
        end
      end
    end else stalled = 1'b0;
  end

  always @(negedge clk)
    if (th.unit_ready && th_nin < 32) begin
      th_pat[th_nin] = th.unit_a;
      th_nin++;
    end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_value = '0; bus.resp_ready = 1'b1;
    th.req_valid = '0; th.req_value = '0; th.resp_ready = 1'b1;
    th.unit_valid = 1'b1; th.unit_y = 1'b1;
    for (int i = 0; i < 4; i++) begin re_on[i] = 1'b0; re_val[i] = 0; end
    repeat (3) @(negedge clk);
    check_rst("rst");
    rst_n = 1'b1;
    tick();
    // Single-requester directed jobs: full, empty, spread, oversize.
    job(0, 32, 32, 0, -1, 32'hFFFF_FFFF, 1); wait_done(400);
    job(1, 0, 0, 0, -1, 32'h0000_0000, 1); wait_done(400);
    job(2, 8, 16, 0, -1, 32'h8888_8888, 1); wait_done(400);
    job(3, 40, 32, 0, -1, 32'hFFFF_FFFF, 1); wait_done(400);
    // All four at once; requester 0 re-requests after its grant and must come last.
    expect_job(0, 4, 11, 0, -1, 32'h8080_8080, 1);
    expect_job(1, 12, 20, 0, -1, 32'h0, 0);
    expect_job(2, 20, 25, 0, -1, 32'h0, 0);
    expect_job(3, 28, 30, 0, -1, 32'h0, 0);
    expect_job(0, 16, 23, 0, -1, 32'hAAAA_AAAA, 1);
    re_on[0] = 1'b1; re_val[0] = 16;
    set_req(0, 4); set_req(1, 12); set_req(2, 20); set_req(3, 28);
    wait_done(2000);
    // Response back-pressure with another request waiting.
    bus.resp_ready = 1'b0;
    job(1, 8, 16, 0, -1, 32'h8888_8888, 1);
    for (int c = 0; c < 400 && !bus.resp_valid; c++) tick();
    chk("stall_resp_seen", bus.resp_valid, 1);
    job(2, 32, 32, 0, -1, 32'hFFFF_FFFF, 1);
    repeat (10) tick();
    chk("stall_busy", bus.busy, 1);
    bus.resp_ready = 1'b1;
    wait_done(800);
    // Unit stops after 20 outputs: timeout after exactly 128 drain cycles.
    stall20 = 1'b1;
    job(3, 8, 16, 1, 128, 32'h8888_8888, 1);
    wait_done(1000);
    stall20 = 1'b0;
    // Reset mid-stream aborts the job silently.
    gnt_q.push_back(0);
    set_req(0, 32);
    for (int c = 0; c < 20 && !bus.unit_ready; c++) tick();
    repeat (5) tick();
    chk("mid_stream_active", bus.unit_ready, 1);
    rst_n = 1'b0;
    #1;
    check_rst("abort");
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk("abort_idle", bus.busy, 0);
    job(2, 8, 16, 0, -1, 32'h8888_8888, 1); wait_done(400);
    // Thermometer instance with an always-valid unit: finishes straight from the stream.
    th.req_valid[0] = 1'b1;
    th.req_value[5:0] = 6'd8;
    for (int c = 0; c < 200 && !th.resp_valid; c++) begin
      @(negedge clk);
      if (th.req_ready[0]) th.req_valid[0] = 1'b0;
    end
    chk("th_resp_valid", th.resp_valid, 1);
    chk("th_pattern", th_pat, 32'h0000_00FF);
    chk("th_bits", th_nin, 32);
    chk("th_resp_id", th.resp_id, 0);
    chk("th_resp_value", th.resp_value, 32);
    chk("th_resp_err", th.resp_err, 0);
    repeat (3) @(negedge clk);
    chk("uq_left", u_q.size(), 0);
    chk("expq_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
